// File: rtl/seq_detector_param.sv
// seq_detector_param
// Programmable serial bit-pattern detector. A pattern of 1..PAT_W bits is
// loaded at runtime and compared against the most recent qualified serial
// bits. Overlapping or non-overlapping detection is selectable, and a
// saturating counter tallies the matches.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous reset, active-low
//   i_cfg_load     load pattern/length/overlap this cycle (drops din)
//   i_cfg_pattern  pattern; bit [len-1] is received first, bit [0] last
//   i_cfg_len      pattern length (0 disables, >PAT_W clamps to PAT_W)
//   i_cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   i_din_valid    qualifies i_din
//   i_din          serial data bit
//   i_cnt_clr      synchronous clear of the match counter
//   o_match        one-cycle registered pulse per detected pattern
//   o_match_cnt    saturating match count
module seq_detector_param #(
  parameter int              PAT_W   = 8,
  parameter int              LEN_W   = 4,
  parameter int              CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = {{(PAT_W-3){1'b0}}, 3'b101},
  parameter int              RST_LEN = 3,
  parameter bit              RST_OVL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0] i_cfg_len,
  input  logic             i_cfg_overlap,
  input  logic             i_din_valid,
  input  logic             i_din,
  input  logic             i_cnt_clr,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt
);

  typedef enum logic {
    S_RUN = 1'b0,
    S_CFG = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [PAT_W-1:0] r_hist, w_hist_next;
  logic [PAT_W-1:0] r_pat, w_pat_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [LEN_W-1:0] r_fill, w_fill_next;
  logic             r_ovl, w_ovl_next;
  logic             r_match, w_match_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  logic [PAT_W-1:0] w_nh;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_len_clamp;
  logic [LEN_W-1:0] w_fill_inc;
  logic             w_fill_ok;
  logic             w_hit;

  // Newest bit enters at hist[0]; the pattern's last bit is pattern[0].
  assign w_nh = {r_hist[PAT_W-2:0], i_din};

  // Mask keeps only the low r_len bits so one comparator serves all lengths.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign w_mask[gi] = (32'(r_len) > gi);
  end

  assign w_len_clamp = (i_cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : i_cfg_len;
  assign w_fill_inc  = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;

  // Enough fresh bits once this one is included: fill+1 >= len.
  assign w_fill_ok = ({1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, r_len};

  assign w_hit = i_din_valid && !i_cfg_load && (r_len != '0) && w_fill_ok &&
                 ((w_nh & w_mask) == (r_pat & w_mask));

  always_comb begin
    w_state_next = S_RUN;
    w_hist_next  = r_hist;
    w_pat_next   = r_pat;
    w_len_next   = r_len;
    w_fill_next  = r_fill;
    w_ovl_next   = r_ovl;
    w_match_next = 1'b0;
    w_cnt_next   = r_cnt;

    if (i_cfg_load) begin
      w_state_next = S_CFG;
      w_pat_next   = i_cfg_pattern;
      w_len_next   = w_len_clamp;
      w_ovl_next   = i_cfg_overlap;
      w_hist_next  = '0;
      w_fill_next  = '0;
    end else if (i_din_valid) begin
      w_hist_next  = w_nh;
      w_match_next = w_hit;
      // Non-overlapping: restart the fill so matched bits are not reused.
      w_fill_next  = (!r_ovl && w_hit) ? '0 : w_fill_inc;
    end

    // Clear beats a simultaneous hit; the match pulse is unaffected.
    if (i_cnt_clr) begin
      w_cnt_next = '0;
    end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
      r_hist  <= '0;
      r_pat   <= RST_PAT;
      r_len   <= LEN_W'(RST_LEN);
      r_fill  <= '0;
      r_ovl   <= RST_OVL;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_hist  <= w_hist_next;
      r_pat   <= w_pat_next;
      r_len   <= w_len_next;
      r_fill  <= w_fill_next;
      r_ovl   <= w_ovl_next;
      r_match <= w_match_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The configuration cycle never reports a match.
  assign o_match     = r_match && (r_state == S_RUN);
  assign o_match_cnt = r_cnt;

endmodule
